// File: rtl/led_fader_pkg.sv
// Shared types and default sizing for the LED fader.
// Fade state encoding plus the default PWM width and duty-step divider.
package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_e;

    // 8-bit PWM with a ~1 s full ramp at 50 MHz
    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_STEP_DIV = 195312;

endpackage : led_fader_pkg

// File: rtl/led_pwm.sv
// PWM output stage: free-running counter compared against the effective duty.
// 1-cycle duty-to-led latency; LED_FADER_GAMMA_EN selects a squared duty curve.
module led_pwm
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_eff;
    logic                led_q;
    logic                led_d;

`ifdef LED_FADER_GAMMA_EN
    localparam int SQ_BITS = 2 * PWM_BITS;

    logic [SQ_BITS-1:0] duty_wide;

    assign duty_wide = SQ_BITS'(duty);
    // Full scale is pinned so the LED still reaches solid on at the top of the ramp
    assign duty_eff  = (duty == DUTY_MAX) ? DUTY_MAX
                                          : PWM_BITS'((duty_wide * duty_wide) >> PWM_BITS);
`else
    assign duty_eff = duty;
`endif

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        led_d     = (duty_eff == DUTY_MAX) || (pwm_cnt_q < duty_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule : led_pwm

// File: rtl/led_fader.sv
// Soft-fade LED driver: linear duty ramp toward the registered level, then PWM.
// level_in to state change 2 cycles, duty to led 1 cycle; optional LED_FADER_GAMMA_EN.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                level_in,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int                  CNT_BITS  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_BITS-1:0] STEP_LAST = CNT_BITS'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP  = DUTY_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    logic                level_q;
    fade_state_e         state_q;
    fade_state_e         state_d;
    logic [CNT_BITS-1:0] step_cnt_q;
    logic [CNT_BITS-1:0] step_cnt_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                tick;

    assign tick = (step_cnt_q == STEP_LAST);

    // A tick on a reversal cycle still moves duty in the old direction;
    // reaching an end point takes priority over the reversal.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        duty_d     = duty_q;
        unique case (state_q)
            ST_OFF: begin
                step_cnt_d = '0;
                if (level_q) begin
                    state_d = ST_UP;
                end
            end
            ST_ON: begin
                step_cnt_d = '0;
                if (!level_q) begin
                    state_d = ST_DOWN;
                end
            end
            ST_UP: begin
                step_cnt_d = tick ? '0 : step_cnt_q + CNT_BITS'(1);
                if (!level_q) begin
                    state_d = ST_DOWN;
                end
                if (tick) begin
                    if (duty_q >= DUTY_TOP) begin
                        duty_d  = DUTY_MAX;
                        state_d = ST_ON;
                    end else begin
                        duty_d = duty_q + PWM_BITS'(1);
                    end
                end
            end
            ST_DOWN: begin
                step_cnt_d = tick ? '0 : step_cnt_q + CNT_BITS'(1);
                if (level_q) begin
                    state_d = ST_UP;
                end
                if (tick) begin
                    if (duty_q <= DUTY_ONE) begin
                        duty_d  = '0;
                        state_d = ST_OFF;
                    end else begin
                        duty_d = duty_q - PWM_BITS'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_OFF;
                step_cnt_d = '0;
                duty_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= 1'b0;
            state_q    <= ST_OFF;
            step_cnt_q <= '0;
            duty_q     <= '0;
        end else begin
            level_q    <= level_in;
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
        end
    end

    assign duty = duty_q;
    assign busy = (state_q == ST_UP) || (state_q == ST_DOWN);

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_q),
        .led  (led)
    );

endmodule : led_fader

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader with a behavioural fade/PWM reference model.
// A second instance with a slow step divider holds duty long enough to inspect PWM periods.
module tb_led_fader;

    localparam int PB   = 4;
    localparam int SD   = 3;
    localparam int SD2  = 64;
    localparam int MAXV = (1 << PB) - 1;

    localparam int M_IDLE_LO = 0;
    localparam int M_RISE    = 1;
    localparam int M_IDLE_HI = 2;
    localparam int M_FALL    = 3;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          level_in = 1'b0;
    logic          lvl2     = 1'b0;
    logic          led, busy, led2, busy2;
    logic [PB-1:0] duty, duty2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .level_in (level_in),
        .led      (led),
        .duty     (duty),
        .busy     (busy)
    );

    led_fader #(.PWM_BITS(PB), .STEP_DIV(SD2)) dut_slow (
        .clk      (clk),
        .rst      (rst),
        .level_in (lvl2),
        .led      (led2),
        .duty     (duty2),
        .busy     (busy2)
    );

    // Reference model: mode, duty and clocks-in-ramp as plain integers
    int   m_lq, m_mode, m_duty, m_rclk, m_cyc, m_e;
    bit   m_tick;
    logic m_led;
    logic m_busy;

    function automatic int eff_of(int d);
`ifdef LED_FADER_GAMMA_EN
        if (d == MAXV) return MAXV;
        return (d * d) >> PB;
`else
        return d;
`endif
    endfunction

    assign m_busy = (m_mode == M_RISE) || (m_mode == M_FALL);

    always @(posedge clk) begin
        if (rst) begin
            m_lq   = 0;
            m_mode = M_IDLE_LO;
            m_duty = 0;
            m_rclk = 0;
            m_cyc  = 0;
            m_led  = 1'b0;
        end else begin
            m_e   = eff_of(m_duty);
            m_led = (m_e == MAXV) || ((m_cyc % (MAXV + 1)) < m_e);
            m_cyc++;
            if (m_mode == M_RISE || m_mode == M_FALL) begin
                m_tick = (m_rclk % SD) == SD - 1;
                m_rclk++;
                if (m_tick && m_mode == M_RISE) begin
                    m_duty++;
                    if (m_duty >= MAXV) begin
                        m_duty = MAXV;
                        m_mode = M_IDLE_HI;
                    end
                end else if (m_tick) begin
                    m_duty = (m_duty > 0) ? m_duty - 1 : 0;
                    if (m_duty == 0) m_mode = M_IDLE_LO;
                end
                if (m_mode == M_RISE || m_mode == M_FALL)
                    m_mode = (m_lq != 0) ? M_RISE : M_FALL;
            end else if (m_mode == M_IDLE_LO && m_lq != 0) begin
                m_mode = M_RISE;
                m_rclk = 0;
            end else if (m_mode == M_IDLE_HI && m_lq == 0) begin
                m_mode = M_FALL;
                m_rclk = 0;
            end
            m_lq = int'(level_in);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        level_in = 1'b0;
        lvl2     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        level_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({led, busy, duty} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got led=%b busy=%b duty=%0d want 0/0/0",
                         i, led, busy, duty);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_1 got busy=%b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || duty !== '0) begin
            errors++;
            $display("FAIL reset_release_2 got busy=%b duty=%0d want 1/0", busy, duty);
        end
    endtask

    task automatic test_full_ramp();
        do_reset();
        level_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_start_1 got busy=%b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || duty !== '0) begin
            errors++;
            $display("FAIL ramp_start_2 got busy=%b duty=%0d want 1/0", busy, duty);
        end
        for (int i = 0; i < MAXV * SD; i++) begin
            @(negedge clk);
            checks++;
            if (duty !== PB'((i + 1) / SD) || busy !== (i < MAXV * SD - 1) || led !== m_led) begin
                errors++;
                $display("FAIL ramp_step i=%0d got duty=%0d busy=%b led=%b want %0d/%b/%b",
                         i, duty, busy, led, (i + 1) / SD, (i < MAXV * SD - 1), m_led);
            end
        end
        checks++;
        if (duty !== PB'(MAXV) || busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp_end got duty=%0d busy=%b want %0d/0", duty, busy, MAXV);
        end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 1'b1) begin
                errors++;
                $display("FAIL on_led i=%0d got led=%b want 1", i, led);
            end
        end
    endtask

    task automatic test_reversal();
        int n;
        do_reset();
        level_in = 1'b1;
        n = 0;
        while (m_duty != 7 && n < 200) begin
            @(negedge clk);
            n++;
            checks++;
            if ({duty, busy, led} !== {PB'(m_duty), m_busy, m_led}) begin
                errors++;
                $display("FAIL rev_rise n=%0d got duty=%0d busy=%b led=%b want %0d/%b/%b",
                         n, duty, busy, led, m_duty, m_busy, m_led);
            end
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL rev_timeout got duty=%0d want 7 within 200 cycles", duty);
            return;
        end
        level_in = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            checks++;
            if ({duty, busy, led} !== {PB'(m_duty), m_busy, m_led}) begin
                errors++;
                $display("FAIL rev_fall i=%0d got duty=%0d busy=%b led=%b want %0d/%b/%b",
                         i, duty, busy, led, m_duty, m_busy, m_led);
            end
            if (i == 1) begin
                checks++;
                if (busy !== 1'b1 || duty !== PB'(7)) begin
                    errors++;
                    $display("FAIL rev_turn got busy=%b duty=%0d want 1/7", busy, duty);
                end
            end
        end
        checks++;
        if (duty !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rev_end got duty=%0d busy=%b want 0/0", duty, busy);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 1'b0) begin
                errors++;
                $display("FAIL off_led i=%0d got led=%b want 0", i, led);
            end
        end
    endtask

    task automatic test_short_blink();
        int peak;
        do_reset();
        peak     = 0;
        level_in = 1'b1;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) level_in = 1'b0;
            @(negedge clk);
            if (int'(duty) > peak) peak = int'(duty);
            checks++;
            if ({duty, busy, led} !== {PB'(m_duty), m_busy, m_led}) begin
                errors++;
                $display("FAIL blink i=%0d got duty=%0d busy=%b led=%b want %0d/%b/%b",
                         i, duty, busy, led, m_duty, m_busy, m_led);
            end
        end
        checks++;
        if (peak != 1 || duty !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL blink_end got peak=%0d duty=%0d busy=%b want 1/0/0", peak, duty, busy);
        end
    endtask

    task automatic test_pwm_shape(input int d);
        int n, highs, eff;
        do_reset();
        lvl2  = 1'b1;
        eff   = eff_of(d);
        n     = 0;
        highs = 0;
        while (int'(duty2) != d && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL pwm_timeout d=%0d got duty=%0d", d, duty2);
            return;
        end
        @(negedge clk);
        n++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n++;
            if (led2 === 1'b1) highs++;
            checks++;
            if (led2 !== ((eff == MAXV) || (((n - 1) % 16) < eff))) begin
                errors++;
                $display("FAIL pwm_phase d=%0d n=%0d got led=%b want %b", d, n, led2,
                         ((eff == MAXV) || (((n - 1) % 16) < eff)));
            end
        end
        checks++;
        if (highs != eff) begin
            errors++;
            $display("FAIL pwm_count d=%0d got highs=%0d want %0d", d, highs, eff);
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            len      = $urandom_range(1, 40);
            level_in = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({duty, busy, led} !== {PB'(m_duty), m_busy, m_led}) begin
                    errors++;
                    $display("FAIL random seg=%0d i=%0d got duty=%0d busy=%b led=%b want %0d/%b/%b",
                             seg, i, duty, busy, led, m_duty, m_busy, m_led);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_ramp();
        test_reversal();
        test_short_blink();
        test_pwm_shape(5);
        test_pwm_shape(12);
`ifdef LED_FADER_GAMMA_EN
        test_pwm_shape(8);
        test_pwm_shape(15);
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_fader
